// File: rtl/prescaled_step_counter_if.sv
// Control and status bundle for prescaled_step_counter.
// The driver side owns the strobes and divide value; the counter side owns the outputs.
interface prescaled_step_counter_if #(
   parameter int PRESCALE_W = 26,
   parameter int OUT_W      = 8
);
   logic                  En;
   logic [PRESCALE_W-1:0] Div_Val;
   logic [1:0]            Mode;
   logic                  Load;
   logic [OUT_W-1:0]      Load_Val;
   logic                  Clear;
   logic [OUT_W-1:0]      Cnt_Out;
   logic                  Tick;
   logic                  Term;
   logic                  Dir;

   modport master (
      output En, Div_Val, Mode, Load, Load_Val, Clear,
      input  Cnt_Out, Tick, Term, Dir
   );

   modport slave (
      input  En, Div_Val, Mode, Load, Load_Val, Clear,
      output Cnt_Out, Tick, Term, Dir
   );
endinterface

// File: rtl/prescaled_step_counter.sv
// Runtime-programmable prescaler feeding an OUT_W-bit step counter.
// The counter has four step modes: up-wrap, down-wrap, up-saturate and bounce.
module prescaled_step_counter #(
   parameter int          PRESCALE_W  = 26,
   parameter int          OUT_W       = 8,
   parameter int unsigned DEFAULT_DIV = 262143
) (
   input logic                     Clk,
   input logic                     RST_N,
   prescaled_step_counter_if.slave bus
);
   localparam logic [PRESCALE_W-1:0] DEFAULT_DIV_C = PRESCALE_W'(DEFAULT_DIV);
   localparam logic [PRESCALE_W-1:0] PRE_ONE_C     = PRESCALE_W'(1);
   localparam logic [OUT_W-1:0]      CNT_ONE_C     = OUT_W'(1);
   localparam logic [OUT_W-1:0]      CNT_MAX_C     = {OUT_W{1'b1}};
   localparam logic [OUT_W-1:0]      CNT_ZERO_C    = {OUT_W{1'b0}};

   logic [PRESCALE_W-1:0] pre_r;
   logic [PRESCALE_W-1:0] div_act_r;
   logic [OUT_W-1:0]      cnt_r;
   logic                  tick_r;
   logic                  term_r;
   logic                  bounce_dir_r;

   logic                  eff_dir_s;
   logic                  wrap_s;
   logic [OUT_W-1:0]      step_val_s;
   logic                  step_term_s;
   logic                  step_bounce_s;
   logic                  dir_s;

   // Bounce direction: endpoints force a reversal, otherwise the stored direction applies.
   always_comb begin
      eff_dir_s = bounce_dir_r;
      if (cnt_r == CNT_MAX_C) begin
         eff_dir_s = 1'b0;
      end else if (cnt_r == CNT_ZERO_C) begin
         eff_dir_s = 1'b1;
      end else begin
         eff_dir_s = bounce_dir_r;
      end
   end

   // Next counter value, terminal flag and bounce state for a tick in the current mode.
   always_comb begin
      step_val_s    = cnt_r;
      step_term_s   = 1'b0;
      step_bounce_s = bounce_dir_r;
      case (bus.Mode)
         2'b00: begin
            step_val_s  = cnt_r + CNT_ONE_C;
            step_term_s = (step_val_s == CNT_ZERO_C);
         end
         2'b01: begin
            step_val_s  = cnt_r - CNT_ONE_C;
            step_term_s = (step_val_s == CNT_MAX_C);
         end
         2'b10: begin
            if (cnt_r == CNT_MAX_C) begin
               step_val_s  = cnt_r;
               step_term_s = 1'b0;
            end else begin
               step_val_s  = cnt_r + CNT_ONE_C;
               step_term_s = (step_val_s == CNT_MAX_C);
            end
         end
         2'b11: begin
            if (eff_dir_s) begin
               step_val_s = cnt_r + CNT_ONE_C;
            end else begin
               step_val_s = cnt_r - CNT_ONE_C;
            end
            step_term_s = (step_val_s == CNT_ZERO_C) || (step_val_s == CNT_MAX_C);
            if (step_val_s == CNT_MAX_C) begin
               step_bounce_s = 1'b0;
            end else if (step_val_s == CNT_ZERO_C) begin
               step_bounce_s = 1'b1;
            end else begin
               step_bounce_s = eff_dir_s;
            end
         end
         default: begin
            step_val_s    = cnt_r;
            step_term_s   = 1'b0;
            step_bounce_s = bounce_dir_r;
         end
      endcase
   end

   // Direction of the next step, derived only from registered state and Mode.
   always_comb begin
      dir_s = 1'b1;
      case (bus.Mode)
         2'b00:   dir_s = 1'b1;
         2'b01:   dir_s = 1'b0;
         2'b10:   dir_s = 1'b1;
         2'b11:   dir_s = eff_dir_s;
         default: dir_s = 1'b1;
      endcase
   end

   assign wrap_s = (pre_r == div_act_r);

   // Prescaler, counter and pulse registers; Clear beats Load beats a step.
   always_ff @(posedge Clk or negedge RST_N) begin
      if (!RST_N) begin
         pre_r        <= '0;
         div_act_r    <= DEFAULT_DIV_C;
         cnt_r        <= '0;
         tick_r       <= 1'b0;
         term_r       <= 1'b0;
         bounce_dir_r <= 1'b1;
      end else if (bus.Clear) begin
         pre_r        <= '0;
         div_act_r    <= bus.Div_Val;
         cnt_r        <= '0;
         tick_r       <= 1'b0;
         term_r       <= 1'b0;
         bounce_dir_r <= 1'b1;
      end else if (bus.Load) begin
         pre_r     <= '0;
         div_act_r <= bus.Div_Val;
         cnt_r     <= bus.Load_Val;
         tick_r    <= 1'b0;
         term_r    <= 1'b0;
      end else if (bus.En) begin
         if (wrap_s) begin
            // Div_Val is only adopted here so a running period is never cut short.
            pre_r        <= '0;
            div_act_r    <= bus.Div_Val;
            cnt_r        <= step_val_s;
            tick_r       <= 1'b1;
            term_r       <= step_term_s;
            bounce_dir_r <= step_bounce_s;
         end else begin
            pre_r  <= pre_r + PRE_ONE_C;
            tick_r <= 1'b0;
            term_r <= 1'b0;
         end
      end else begin
         tick_r <= 1'b0;
         term_r <= 1'b0;
      end
   end

   assign bus.Cnt_Out = cnt_r;
   assign bus.Tick    = tick_r;
   assign bus.Term    = term_r;
   assign bus.Dir     = dir_s;
endmodule

// File: tb/tb_prescaled_step_counter.sv
// Directed bench for prescaled_step_counter; the reset divider is shortened to 255
// so the out-of-reset period (256 clocks) stays cheap to simulate.
module tb_prescaled_step_counter;
   localparam int PW = 26;
   localparam int OW = 8;

   logic Clk;
   logic RST_N;
   int   checks;
   int   failures;

   prescaled_step_counter_if #(.PRESCALE_W(PW), .OUT_W(OW)) bus ();

   prescaled_step_counter #(.PRESCALE_W(PW), .OUT_W(OW), .DEFAULT_DIV(255)) dut (
      .Clk  (Clk),
      .RST_N(RST_N),
      .bus  (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Count edges until Tick is seen, giving up after bound edges.
   task automatic wait_tick(input int bound, output int n);
      n = 0;
      while (n < bound) begin
         step();
         n++;
         if (bus.Tick === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      bus.En = 1'b0; bus.Clear = 1'b0; bus.Load = 1'b0;
      bus.Load_Val = '0; bus.Mode = 2'b00; bus.Div_Val = 26'd255;
      repeat (3) step();
      checks++;
      if ({bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got cnt=%0d tick=%0b term=%0b dir=%0b want 0 0 0 1",
                  bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir);
      end
      RST_N = 1'b1;
      bus.En = 1'b1;
   endtask

   task automatic test_default_div();
      int n;
      wait_tick(600, n);
      checks++;
      if ({n, bus.Cnt_Out, bus.Term} !== {32'd256, 8'd1, 1'b0}) begin
         failures++;
         $display("FAIL default_first_tick got edges=%0d cnt=%0d term=%0b want 256 1 0", n, bus.Cnt_Out, bus.Term);
      end
      wait_tick(600, n);
      checks++;
      if ({n, bus.Cnt_Out} !== {32'd256, 8'd2}) begin
         failures++;
         $display("FAIL default_period got edges=%0d cnt=%0d want 256 2", n, bus.Cnt_Out);
      end
   endtask

   task automatic test_up_wrap();
      int n;
      bus.Div_Val = 26'd3; bus.Mode = 2'b00; bus.Load_Val = 8'd254; bus.Load = 1'b1;
      step();
      bus.Load = 1'b0;
      checks++;
      if ({bus.Cnt_Out, bus.Tick} !== {8'd254, 1'b0}) begin
         failures++;
         $display("FAIL upwrap_load got cnt=%0d tick=%0b want 254 0", bus.Cnt_Out, bus.Tick);
      end
      wait_tick(20, n);
      checks++;
      if ({n, bus.Cnt_Out, bus.Term} !== {32'd4, 8'd255, 1'b0}) begin
         failures++;
         $display("FAIL upwrap_255 got edges=%0d cnt=%0d term=%0b want 4 255 0", n, bus.Cnt_Out, bus.Term);
      end
      wait_tick(20, n);
      checks++;
      if ({n, bus.Cnt_Out, bus.Term, bus.Dir} !== {32'd4, 8'd0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL upwrap_0 got edges=%0d cnt=%0d term=%0b dir=%0b want 4 0 1 1",
                  n, bus.Cnt_Out, bus.Term, bus.Dir);
      end
      step();
      bus.En = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({bus.Cnt_Out, bus.Tick} !== {8'd0, 1'b0}) begin
            failures++;
            $display("FAIL enable_freeze cycle=%0d got cnt=%0d tick=%0b want 0 0", i, bus.Cnt_Out, bus.Tick);
         end
      end
      bus.En = 1'b1;
      wait_tick(20, n);
      checks++;
      if ({n, bus.Cnt_Out} !== {32'd3, 8'd1}) begin
         failures++;
         $display("FAIL enable_resume got edges=%0d cnt=%0d want 3 1", n, bus.Cnt_Out);
      end
   endtask

   task automatic test_down_wrap();
      logic [7:0] exp_cnt [3];
      logic       exp_term [3];
      exp_cnt = '{8'd255, 8'd254, 8'd253};
      exp_term = '{1'b1, 1'b0, 1'b0};
      bus.Div_Val = 26'd0; bus.Mode = 2'b01; bus.Clear = 1'b1;
      step();
      bus.Clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir} !== {exp_cnt[i], 1'b1, exp_term[i], 1'b0}) begin
            failures++;
            $display("FAIL down_wrap step=%0d got cnt=%0d tick=%0b term=%0b dir=%0b want %0d 1 %0b 0",
                     i, bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir, exp_cnt[i], exp_term[i]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_cnt [4];
      logic       exp_term [4];
      exp_cnt = '{8'd254, 8'd255, 8'd255, 8'd255};
      exp_term = '{1'b0, 1'b1, 1'b0, 1'b0};
      bus.Mode = 2'b10; bus.Load_Val = 8'd253; bus.Load = 1'b1;
      step();
      bus.Load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({bus.Cnt_Out, bus.Tick, bus.Term} !== {exp_cnt[i], 1'b1, exp_term[i]}) begin
            failures++;
            $display("FAIL saturate step=%0d got cnt=%0d tick=%0b term=%0b want %0d 1 %0b",
                     i, bus.Cnt_Out, bus.Tick, bus.Term, exp_cnt[i], exp_term[i]);
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] exp_cnt [5];
      logic       exp_term [5];
      logic       exp_dir [5];
      exp_cnt  = '{8'd255, 8'd254, 8'd253, 8'd0, 8'd1};
      exp_term = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_dir  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      bus.Mode = 2'b11; bus.Load_Val = 8'd254; bus.Load = 1'b1;
      step();
      bus.Load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            bus.Load_Val = 8'd1; bus.Load = 1'b1;
            step();
            bus.Load = 1'b0;
         end
         step();
         checks++;
         if ({bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir} !== {exp_cnt[i], 1'b1, exp_term[i], exp_dir[i]}) begin
            failures++;
            $display("FAIL bounce step=%0d got cnt=%0d tick=%0b term=%0b dir=%0b want %0d 1 %0b %0b",
                     i, bus.Cnt_Out, bus.Tick, bus.Term, bus.Dir, exp_cnt[i], exp_term[i], exp_dir[i]);
         end
      end
   endtask

   task automatic test_div_change();
      int n;
      bus.Mode = 2'b00; bus.Div_Val = 26'd7; bus.Clear = 1'b1;
      step();
      bus.Clear = 1'b0;
      repeat (3) step();
      bus.Div_Val = 26'd1;
      wait_tick(30, n);
      checks++;
      if ({n, bus.Cnt_Out} !== {32'd5, 8'd1}) begin
         failures++;
         $display("FAIL div_change_current got edges=%0d cnt=%0d want 5 1", n, bus.Cnt_Out);
      end
      for (int i = 0; i < 2; i++) begin
         wait_tick(30, n);
         checks++;
         if ({n, bus.Cnt_Out} !== {32'd2, 8'(i + 2)}) begin
            failures++;
            $display("FAIL div_change_new period=%0d got edges=%0d cnt=%0d want 2 %0d", i, n, bus.Cnt_Out, i + 2);
         end
      end
   endtask

   task automatic test_clear_load();
      bus.Load_Val = 8'd77; bus.Clear = 1'b1; bus.Load = 1'b1;
      step();
      bus.Clear = 1'b0; bus.Load = 1'b0;
      checks++;
      if ({bus.Cnt_Out, bus.Tick} !== {8'd0, 1'b0}) begin
         failures++;
         $display("FAIL clear_over_load got cnt=%0d tick=%0b want 0 0", bus.Cnt_Out, bus.Tick);
      end
   endtask

   task automatic test_async_reset();
      int n;
      wait_tick(30, n);
      wait_tick(30, n);
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({bus.Cnt_Out, bus.Tick, bus.Term} !== {8'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got cnt=%0d tick=%0b term=%0b want 0 0 0", bus.Cnt_Out, bus.Tick, bus.Term);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_default_div();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_bounce();
      test_div_change();
      test_clear_load();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prescaled_step_counter.md
Name: prescaled_step_counter

Overview:
Parametrised prescaler plus N-bit step counter for LED/display timing. A runtime-programmable prescaler generates a tick every Div_Val+1 enabled clocks. Each tick advances an OUT_W-bit counter in one of four modes: up-wrap, down-wrap, up-saturate, bounce. Supports synchronous load/clear and terminal-event flagging; drives LED banks and feeds downstream blocks as a timebase.

Parameters:
PRESCALE_W, 26, width of prescaler counter and Div_Val.
OUT_W, 8, width of Cnt_Out.
DEFAULT_DIV, 262143 (2^18-1), divide value used out of reset; must fit in PRESCALE_W bits.

Ports:
Clk  input  1  system clock.
RST_N  input  1  reset, asynchronous, active-low.
En  input  1  prescaler count enable.
Div_Val  input  PRESCALE_W  tick period minus one; sampled only at the sample points listed under Behaviour.
Mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 bounce.
Load  input  1  synchronous load strobe.
Load_Val  input  OUT_W  value loaded into Cnt_Out.
Clear  input  1  synchronous clear strobe.
Cnt_Out  output  OUT_W  step counter value (registered).
Tick  output  1  one-cycle pulse, high in the same cycle Cnt_Out shows its new stepped value.
Term  output  1  one-cycle pulse coincident with Tick when a terminal event occurs.
Dir  output  1  direction of the next step: 1 = up, 0 = down.

Behaviour:
- Reset (async, RST_N low): Pre=0, Div_Act=DEFAULT_DIV, Cnt_Out=0, Tick=0, Term=0, bounce direction register=1. Recovery is synchronous to Clk.
- Priority per clock edge: Clear > Load > step.
- Clear (any En): Pre<=0, Cnt_Out<=0, bounce direction<=1, Div_Act<=Div_Val, Tick<=0, Term<=0.
- Load (any En): Cnt_Out<=Load_Val, Pre<=0, Div_Act<=Div_Val, Tick<=0, Term<=0. Bounce direction unchanged.
- En=0 and no Clear/Load: Pre, Cnt_Out, Div_Act hold; Tick=0, Term=0.
- En=1:
  - Pre!=Div_Act: Pre<=Pre+1, Tick=0, Term=0.
  - Pre==Div_Act: Pre<=0, Div_Act<=Div_Val, Tick<=1, Cnt_Out steps per Mode.
- Tick period is Div_Act+1 enabled cycles. Div_Val=0 gives a tick every enabled cycle. Changes to Div_Val take effect only at the next wrap, Clear or Load; no glitch periods.
- Step rules (MAX = 2^OUT_W-1), evaluated with the Mode value current at the tick:
  - 00: Cnt+1 modulo 2^OUT_W; Term=1 when the new value is 0.
  - 01: Cnt-1 modulo 2^OUT_W; Term=1 when the new value is MAX.
  - 10: Cnt+1 capped at MAX; Term=1 only on the step that reaches MAX. Ticks while already at MAX keep Tick=1, Term=0, value held.
  - 11 (bounce): effective direction is down if Cnt==MAX, up if Cnt==0, otherwise the bounce register. New value = Cnt±1. Bounce register <= 0 if new==MAX, 1 if new==0, else the effective direction. Term=1 when new is 0 or MAX.
- Dir output is combinational from registered state: Mode 00/10 -> 1; Mode 01 -> 0; Mode 11 -> effective direction.
- Mode changes mid-period do not reset Pre. Entering bounce mode keeps the stored bounce register.
- Term is never high without Tick. Both are registered, with no combinational path from inputs.
- Arithmetic: Pre comparison is an exact PRESCALE_W-bit equality, with no truncation. Cnt arithmetic is OUT_W bits wide.

Test Plan:
1. Reset, then DEFAULT_DIV with En=1 held. Tick first pulses at cycle 262144 after reset release; Cnt_Out=1; period 262144 clocks.
2. Div_Val=3, Mode=00, Load_Val=254 via Load. Ticks every 4 clocks; Cnt_Out 255, 0 (Term=1), 1. En low for 5 cycles freezes Pre and suppresses Tick.
3. Div_Val=0, Mode=01, Clear. First tick gives Cnt_Out=255 with Term=1, then 254, 253 on consecutive cycles; Dir=0.
4. Div_Val=0, Mode=10, Load 253. Sequence is 254, 255 (Term=1), then 255, 255 with Tick=1 and Term=0.
5. Div_Val=0, Mode=11, Load 254 with bounce register=1. Sequence is 255 (Term, Dir->0), 254, 253; then Load 1 gives 0 (Term, Dir->1), 1.
6. Div_Val=7 running, change Div_Val to 1 mid-period: the current period still lasts 8 clocks and subsequent periods last 2. Clear and Load in the same cycle: Clear wins, Cnt_Out=0. Asserting RST_N mid-period zeroes outputs immediately, without waiting for a clock edge.
